// File: rtl/clock_pkg.sv
// Shared constants and helpers for the BCD time-of-day counter.
//
// Contents:
//   BCD_SEC_MAX / BCD_MIN_MAX / BCD_HR_MAX - last legal BCD value of each field
//   BCD_NOON                               - first afternoon hour (pm threshold)
//   clog2()                                - prescaler width helper
package clock_pkg;

    localparam logic [7:0] BCD_SEC_MAX = 8'h59;
    localparam logic [7:0] BCD_MIN_MAX = 8'h59;
    localparam logic [7:0] BCD_HR_MAX  = 8'h23;
    localparam logic [7:0] BCD_NOON    = 8'h12;

    // Bits needed to hold 0..n-1. Never returns less than 1, so a
    // degenerate CLK_HZ of 1 still yields a legal vector width.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter: counts 00..MAX_BCD and wraps to 00.
//
// Ports:
//   clk    in   system clock
//   clr    in   synchronous clear to 8'h00, has priority over inc
//   inc    in   advance by one on this edge
//   value  out  {tens, ones} BCD value, registered
//   wrap   out  combinational; high when inc is applied at MAX_BCD
module bcd_mod_counter #(
    parameter logic [7:0] MAX_BCD = 8'h59
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] value,
    output logic       wrap
);

    logic [7:0] value_q;
    logic [7:0] value_next;
    logic       at_max;

    assign at_max = (value_q == MAX_BCD);
    assign wrap   = inc & at_max;
    assign value  = value_q;

    // Ones digit 9 rolls into the tens digit; the terminal value wraps
    // whole, so hours 23 goes to 00 without ever passing through 24.
    always_comb begin
        value_next = value_q;
        if (at_max) begin
            value_next = 8'h00;
        end else if (value_q[3:0] == 4'd9) begin
            value_next = {value_q[7:4] + 4'd1, 4'd0};
        end else begin
            value_next = {value_q[7:4], value_q[3:0] + 4'd1};
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            value_q <= 8'h00;
        end else if (inc) begin
            value_q <= value_next;
        end
    end

endmodule

// File: rtl/bcd_timekeeper.sv
// 24-hour BCD time-of-day counter (HH:MM:SS) with 1 Hz prescaler and
// a set mode for adjusting hours and minutes from single-cycle pulses.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   run_en       in   time advances on prescaler tick (ignored in set mode)
//   set_mode     in   adjust mode; counting frozen, seconds held at 00
//   inc_hr       in   +1 hour pulse, set mode only (23 -> 00, no carry)
//   inc_min      in   +1 minute pulse, set mode only (59 -> 00, no carry)
//   hours_bcd    out  BCD hours 00..23
//   minutes_bcd  out  BCD minutes 00..59
//   seconds_bcd  out  BCD seconds 00..59
//   sec_tick     out  high in the cycle a counted seconds update is visible
//   pm           out  hours_bcd >= 12
module bcd_timekeeper
    import clock_pkg::*;
#(
    parameter int CLK_HZ = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run_en,
    input  logic       set_mode,
    input  logic       inc_hr,
    input  logic       inc_min,
    output logic [7:0] hours_bcd,
    output logic [7:0] minutes_bcd,
    output logic [7:0] seconds_bcd,
    output logic       sec_tick,
    output logic       pm
);

    localparam int PRESC_W = clog2(CLK_HZ);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);

    logic [PRESC_W-1:0] presc_q;
    logic               tick;
    logic               sec_tick_q;
    logic               sec_wrap;
    logic               min_wrap;
    logic               min_inc;
    logic               hr_inc;
    // Midnight rollover has no consumer downstream.
    logic               unused_hr_wrap;

    assign tick = run_en & ~set_mode & (presc_q == PRESC_LAST);

    // Pausing holds the sub-second phase; set mode zeroes it so the first
    // tick after leaving set mode lands a full second later.
    always_ff @(posedge clk) begin
        if (reset || set_mode) begin
            presc_q <= '0;
        end else if (run_en) begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sec_tick_q <= 1'b0;
        end else begin
            sec_tick_q <= tick;
        end
    end

    // In set mode the button pulses replace the carry chain, so a minute
    // wrap during adjustment never reaches the hours.
    assign min_inc = set_mode ? inc_min : sec_wrap;
    assign hr_inc  = set_mode ? inc_hr  : min_wrap;

    bcd_mod_counter #(.MAX_BCD(BCD_SEC_MAX)) u_sec (
        .clk   (clk),
        .clr   (reset | set_mode),
        .inc   (tick),
        .value (seconds_bcd),
        .wrap  (sec_wrap)
    );

    bcd_mod_counter #(.MAX_BCD(BCD_MIN_MAX)) u_min (
        .clk   (clk),
        .clr   (reset),
        .inc   (min_inc),
        .value (minutes_bcd),
        .wrap  (min_wrap)
    );

    bcd_mod_counter #(.MAX_BCD(BCD_HR_MAX)) u_hr (
        .clk   (clk),
        .clr   (reset),
        .inc   (hr_inc),
        .value (hours_bcd),
        .wrap  (unused_hr_wrap)
    );

    assign sec_tick = sec_tick_q;
    assign pm       = (hours_bcd >= BCD_NOON);

endmodule
